// File: rtl/poly_tx_fir.sv
// poly_tx_fir -- polyphase transmit FIR (BPSK pulse shaper), N_CH channels
// sharing one coefficient bank.
//
// One symbol vector is accepted per OVER_SAMP enabled cycles; every enabled
// cycle produces one output sample per channel for the current phase.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset (wins over everything)
//   i_enable     clock enable; coefficient writes ignore it
//   i_valid      symbol vector offered
//   i_sym        symbol bits, one per channel (0 -> +1, 1 -> -1)
//   o_ready      high on the enabled last-phase cycle (symbol boundary)
//   i_coef_we    coefficient write strobe
//   i_coef_addr  coefficient index k = tap*OVER_SAMP + phase
//   i_coef_data  signed coefficient, NBF_COEFF fraction bits
//   o_data       channel c at [c*NB_OUT +: NB_OUT], NBF_OUT fraction bits
//   o_valid      o_data/o_phase refreshed last cycle
//   o_phase      phase the current o_data belongs to
//   o_underrun   pulse after a symbol boundary that accepted nothing
//
// Build option
//   POLY_TX_FIR_SAT_EN  defined: saturate output to NB_OUT range;
//                       undefined: drop MSBs (two's-complement wrap).
module poly_tx_fir #(
  parameter int OVER_SAMP = 8,
  parameter int N_BAUDS   = 7,
  parameter int NB_COEFF  = 10,
  parameter int NBF_COEFF = 8,
  parameter int N_CH      = 2,
  parameter int NB_OUT    = 10,
  parameter int NBF_OUT   = 7
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_enable,
  input  logic                                   i_valid,
  input  logic [N_CH-1:0]                        i_sym,
  output logic                                   o_ready,
  input  logic                                   i_coef_we,
  input  logic [$clog2(OVER_SAMP*N_BAUDS)-1:0]   i_coef_addr,
  input  logic [NB_COEFF-1:0]                    i_coef_data,
  output logic [N_CH*NB_OUT-1:0]                 o_data,
  output logic                                   o_valid,
  output logic [$clog2(OVER_SAMP)-1:0]           o_phase,
  output logic                                   o_underrun
);

  localparam int PH_W   = $clog2(OVER_SAMP);
  localparam int ADDR_W = $clog2(OVER_SAMP * N_BAUDS);
  localparam int SUM_W  = NB_COEFF + $clog2(N_BAUDS) + 1;
  localparam int DROP   = NBF_COEFF - NBF_OUT;
  localparam int EXT_W  = (SUM_W > NB_OUT) ? SUM_W : NB_OUT;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVER_SAMP - 1);

  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PH_W-1:0]         phaseOut_q;
  logic [N_BAUDS-1:0]      tapValid_q [N_CH];
  logic [N_BAUDS-1:0]      tapValid_d [N_CH];
  logic [N_BAUDS-1:0]      tapBit_q   [N_CH];
  logic [N_BAUDS-1:0]      tapBit_d   [N_CH];
  logic [NB_COEFF-1:0]     coef_q     [N_BAUDS][OVER_SAMP];
  logic [N_CH*NB_OUT-1:0]  data_q, data_d;
  logic                    valid_q;
  logic                    underrun_q, underrun_d;
  logic                    boundary;
  logic                    accept;
  logic signed [SUM_W-1:0] sum [N_CH];

  // The last phase of an enabled cycle is the only point a symbol can enter.
  assign boundary = i_enable && (phase_q == LAST_PH);
  assign accept   = boundary && i_valid;
  assign o_ready  = boundary;

  // Next phase and shifted tap lines; tap 0 is the LSB and takes the new
  // symbol, or an invalid slot when nothing was accepted.
  always_comb begin
    phase_d    = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
    underrun_d = boundary && !accept;
    for (int c = 0; c < N_CH; c++) begin
      tapValid_d[c] = {tapValid_q[c][N_BAUDS-2:0], accept};
      tapBit_d[c]   = {tapBit_q[c][N_BAUDS-2:0], accept & i_sym[c]};
    end
  end

  // Full-precision per-channel sum for the current phase; wide enough that
  // N_BAUDS terms of magnitude up to 2^(NB_COEFF-1) can never overflow.
  always_comb begin
    logic signed [SUM_W-1:0] term;
    for (int c = 0; c < N_CH; c++) begin
      sum[c] = '0;
      for (int b = 0; b < N_BAUDS; b++) begin
        term = {{(SUM_W-NB_COEFF){coef_q[b][phase_q][NB_COEFF-1]}}, coef_q[b][phase_q]};
        if (!tapValid_q[c][b]) begin
          term = '0;
        end else if (tapBit_q[c][b]) begin
          term = -term;
        end
        sum[c] = sum[c] + term;
      end
    end
  end

`ifdef POLY_TX_FIR_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((2 ** (NB_OUT - 1)) - 1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

  // Floor-truncate the fraction down to NBF_OUT, then fit into NB_OUT bits.
  always_comb begin
    logic signed [EXT_W-1:0] scaled;
    data_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      scaled = EXT_W'(sum[c]);
      scaled = scaled >>> DROP;
`ifdef POLY_TX_FIR_SAT_EN
      if (scaled > OUT_MAX) begin
        data_d[c*NB_OUT +: NB_OUT] = NB_OUT'(OUT_MAX);
      end else if (scaled < OUT_MIN) begin
        data_d[c*NB_OUT +: NB_OUT] = NB_OUT'(OUT_MIN);
      end else begin
        data_d[c*NB_OUT +: NB_OUT] = NB_OUT'(scaled);
      end
`else
      data_d[c*NB_OUT +: NB_OUT] = NB_OUT'(scaled);
`endif
    end
  end

  // Coefficient bank: written regardless of the enable; out-of-range
  // addresses match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < N_BAUDS; b++) begin
        for (int p = 0; p < OVER_SAMP; p++) begin
          coef_q[b][p] <= '0;
        end
      end
    end else if (i_coef_we) begin
      for (int b = 0; b < N_BAUDS; b++) begin
        for (int p = 0; p < OVER_SAMP; p++) begin
          if (i_coef_addr == ADDR_W'(b * OVER_SAMP + p)) begin
            coef_q[b][p] <= i_coef_data;
          end
        end
      end
    end
  end

  // Phase, taps and output registers. o_data/o_phase hold through disabled
  // cycles while o_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      phaseOut_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        tapValid_q[c] <= '0;
        tapBit_q[c]   <= '0;
      end
    end else begin
      valid_q    <= i_enable;
      underrun_q <= underrun_d;
      if (i_enable) begin
        phase_q    <= phase_d;
        phaseOut_q <= phase_q;
        data_q     <= data_d;
      end
      if (boundary) begin
        for (int c = 0; c < N_CH; c++) begin
          tapValid_q[c] <= tapValid_d[c];
          tapBit_q[c]   <= tapBit_d[c];
        end
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_phase    = phaseOut_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_poly_tx_fir.sv
// tb_poly_tx_fir -- self-checking bench for poly_tx_fir (default parameters).
// A behavioural reference model predicts each output sample when the cycle
// is driven; predictions queue up and are compared when o_valid appears.
// Table of single-coefficient impulse cases plus hand-written sequences for
// reset, underrun, overflow, enable gaps and coefficient writes.
module tb_poly_tx_fir;

  localparam int OS   = 8;
  localparam int NBD  = 7;
  localparam int NCOEF = OS * NBD;
`ifdef POLY_TX_FIR_SAT_EN
  localparam int OVF_EXP = 511;
`else
  localparam int OVF_EXP = -260;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        vld;
  logic [1:0]  sym;
  logic        ready;
  logic        cwe;
  logic [5:0]  caddr;
  logic [9:0]  cdata;
  logic [19:0] oData;
  logic        oValid;
  logic [2:0]  oPhase;
  logic        oUnderrun;

  poly_tx_fir dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (en),
    .i_valid     (vld),
    .i_sym       (sym),
    .o_ready     (ready),
    .i_coef_we   (cwe),
    .i_coef_addr (caddr),
    .i_coef_data (cdata),
    .o_data      (oData),
    .o_valid     (oValid),
    .o_phase     (oPhase),
    .o_underrun  (oUnderrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch0;
    int ch1;
    int ph;
  } sb_item_t;

  typedef struct {
    int         addr;
    int         coef;
    logic [1:0] sym;
    int         expPh;
    int         expCh0;
    int         expCh1;
  } impulse_t;

  sb_item_t sbQ[$];

  int nChecks = 0;
  int nErrors = 0;

  int mPhase;
  int mCoef [NCOEF];
  bit mTv [2][NBD];
  bit mTb [2][NBD];
  bit expValid;
  bit expUnder;
  int holdD0, holdD1, holdPh;
  int actD0, actD1;
  int underrunCount;
  int nzCount, nzCh0, nzCh1, nzPh;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int modelChan(input int c);
    int s;
    int t;
    s = 0;
    for (int b = 0; b < NBD; b++) begin
      if (mTv[c][b]) begin
        if (mTb[c][b]) s = s - mCoef[b*OS + mPhase];
        else           s = s + mCoef[b*OS + mPhase];
      end
    end
    t = (s < 0) ? -((-s + 1) / 2) : s / 2;
`ifdef POLY_TX_FIR_SAT_EN
    if (t > 511)  t = 511;
    if (t < -512) t = -512;
`else
    t = t & 1023;
    if (t >= 512) t = t - 1024;
`endif
    return t;
  endfunction

  task automatic modelReset();
    mPhase = 0;
    for (int k = 0; k < NCOEF; k++) mCoef[k] = 0;
    for (int c = 0; c < 2; c++) begin
      for (int b = 0; b < NBD; b++) begin
        mTv[c][b] = 1'b0;
        mTb[c][b] = 1'b0;
      end
    end
    sbQ.delete();
    expValid = 1'b0;
    expUnder = 1'b0;
    holdD0 = 0;
    holdD1 = 0;
    holdPh = 0;
  endtask

  // One clock: predict before the edge, advance the model at the edge,
  // compare on the falling edge.
  task automatic runCycle();
    bit       expReady;
    bit       bnd;
    bit       acc;
    int       a0, a1, ph;
    sb_item_t it;
    #1;
    expReady = en && (mPhase == OS - 1);
    bnd = expReady;
    acc = bnd && vld;
    if (!rst) checkOutput("ready", int'(ready), int'(expReady));
    if (!rst && en) begin
      it.ch0 = modelChan(0);
      it.ch1 = modelChan(1);
      it.ph  = mPhase;
      sbQ.push_back(it);
    end
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      if (cwe && int'(caddr) < NCOEF) mCoef[int'(caddr)] = int'($signed(cdata));
      if (en) begin
        if (bnd) begin
          for (int c = 0; c < 2; c++) begin
            for (int b = NBD - 1; b > 0; b--) begin
              mTv[c][b] = mTv[c][b-1];
              mTb[c][b] = mTb[c][b-1];
            end
            mTv[c][0] = acc;
            mTb[c][0] = acc && sym[c];
          end
        end
        mPhase = (mPhase + 1) % OS;
      end
      expValid = en;
      expUnder = bnd && !acc;
    end
    @(negedge clk);
    a0 = int'($signed(oData[9:0]));
    a1 = int'($signed(oData[19:10]));
    ph = int'(oPhase);
    checkOutput("valid", int'(oValid), int'(expValid));
    checkOutput("underrun", int'(oUnderrun), int'(expUnder));
    if (oUnderrun) underrunCount++;
    if (oValid) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL sbUnderflow: got o_valid=1 required no pending sample");
      end else begin
        it = sbQ.pop_front();
        checkOutput("ch0", a0, it.ch0);
        checkOutput("ch1", a1, it.ch1);
        checkOutput("phase", ph, it.ph);
        holdD0 = it.ch0;
        holdD1 = it.ch1;
        holdPh = it.ph;
      end
    end else begin
      checkOutput("holdCh0", a0, holdD0);
      checkOutput("holdCh1", a1, holdD1);
      checkOutput("holdPhase", ph, holdPh);
    end
    actD0 = a0;
    actD1 = a1;
    if (oValid && (a0 != 0 || a1 != 0)) begin
      nzCount++;
      nzCh0 = a0;
      nzCh1 = a1;
      nzPh  = ph;
    end
  endtask

  task automatic applyStimulus(input bit e, input bit v, input logic [1:0] s,
                               input bit we, input int addr, input int data);
    en    = e;
    vld   = v;
    sym   = s;
    cwe   = we;
    caddr = 6'(addr);
    cdata = 10'(data);
    runCycle();
    cwe   = 1'b0;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 2'b00, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    impulse_t tbl [5];
    tbl[0] = '{addr: 8,  coef: 128,  sym: 2'b10, expPh: 0, expCh0: 64,   expCh1: -64};
    tbl[1] = '{addr: 3,  coef: -100, sym: 2'b01, expPh: 3, expCh0: 50,   expCh1: -50};
    tbl[2] = '{addr: 50, coef: 511,  sym: 2'b00, expPh: 2, expCh0: 255,  expCh1: 255};
    tbl[3] = '{addr: 21, coef: 3,    sym: 2'b11, expPh: 5, expCh0: -2,   expCh1: -2};
    tbl[4] = '{addr: 55, coef: -512, sym: 2'b10, expPh: 7, expCh0: -256, expCh1: 256};

    rst = 1'b1; en = 1'b1; vld = 1'b0; sym = 2'b00;
    cwe = 1'b0; caddr = '0; cdata = '0;
    underrunCount = 0;
    nzCount = 0; nzCh0 = 0; nzCh1 = 0; nzPh = 0;
    actD0 = 0; actD1 = 0;
    modelReset();

    // Reset with enable, valid and a write all asserted: reset must win.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 2'b11, 1, 5, 77);
      checkOutput("rstData", int'(oData), 0);
      checkOutput("rstValid", int'(oValid), 0);
      checkOutput("rstPhase", int'(oPhase), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < OS; i++) applyStimulus(1, 0, 2'b00, 0, 0, 0);

    // Three empty boundaries give three underrun pulses.
    underrunCount = 0;
    for (int i = 0; i < 3 * OS; i++) applyStimulus(1, 0, 2'b00, 0, 0, 0);
    checkOutput("underrunPulses", underrunCount, 3);

    // Single-coefficient impulse responses.
    foreach (tbl[i]) begin
      doReset(2);
      applyStimulus(0, 0, 2'b00, 1, tbl[i].addr, tbl[i].coef);
      nzCount = 0;
      for (int k = 0; k < OS - 1; k++) applyStimulus(1, 0, 2'b00, 0, 0, 0);
      applyStimulus(1, 1, tbl[i].sym, 0, 0, 0);
      for (int k = 0; k < 66; k++) applyStimulus(1, 0, 2'b00, 0, 0, 0);
      checkOutput("impNonzeroCount", nzCount, 1);
      checkOutput("impPhase", nzPh, tbl[i].expPh);
      checkOutput("impCh0", nzCh0, tbl[i].expCh0);
      checkOutput("impCh1", nzCh1, tbl[i].expCh1);
    end

    // Overflow: every coefficient at full scale, all taps valid and +1.
    doReset(1);
    for (int k = 0; k < NCOEF; k++) applyStimulus(0, 0, 2'b00, 1, k, 511);
    for (int k = 0; k < 8 * OS; k++) applyStimulus(1, 1, 2'b00, 0, 0, 0);
    checkOutput("ovfCh0", actD0, OVF_EXP);
    checkOutput("ovfCh1", actD1, OVF_EXP);
    for (int k = 0; k < 8 * OS; k++) applyStimulus(1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < OS; k++) begin
      applyStimulus(1, 0, 2'b00, 0, 0, 0);
      checkOutput("drainCh0", actD0, 0);
      checkOutput("drainCh1", actD1, 0);
    end

    // Coefficient writes during a run, with an enable gap in between.
    doReset(1);
    underrunCount = 0;
    applyStimulus(0, 0, 2'b00, 1, 0, 100);
    for (int k = 0; k < OS; k++) applyStimulus(1, 1, 2'b00, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    checkOutput("coefOld", actD0, 50);
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 1, 60, 200);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 2'b00, 0, 0, 0);
      checkOutput("gapPhase", int'(oPhase), 3);
      checkOutput("gapValid", int'(oValid), 0);
    end
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    checkOutput("resumePhase", int'(oPhase), 4);
    checkOutput("resumeValid", int'(oValid), 1);
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 1, 0, -50);
    applyStimulus(1, 1, 2'b00, 0, 0, 0);
    checkOutput("coefNew", actD0, -25);
    checkOutput("gapNoUnderrun", underrunCount, 0);

    // Reset in the middle of a symbol period.
    for (int k = 0; k < OS && mPhase != 4; k++) applyStimulus(1, 0, 2'b00, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 2'b00, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1, 0, 2'b00, 0, 0, 0);
    checkOutput("postRstPhase", int'(oPhase), 0);
    checkOutput("postRstValid", int'(oValid), 1);
    checkOutput("postRstData", int'(oData), 0);

    applyStimulus(0, 0, 2'b00, 0, 0, 0);
    checkOutput("sbDrained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
